write_ptr_ctrl: RTL and testbench

Parametrised write-side pointer/flag controller for the async FIFO; successor to the fixed-depth write pointer block.
Keeps binary and Gray write pointers and takes the two-flop-synchronised Gray read pointer. Produces full, a programmable almost-full flag, an exact occupancy count, and a sticky overflow error.
Sits in the write clock domain between the write-side user interface and the dual-port FIFO memory / write-to-read pointer synchroniser.

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/gray2bin_conv.sv | 14 +
 rtl/write_ptr_ctrl.sv | 97 +++++++++
 tb/tb_write_ptr_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO pointer logic (write and read sides).
// Gray/binary helpers operate on up to 32-bit pointers.
package async_fifo_pkg;

   localparam int DEFAULT_ADDR_W = 9;
   localparam int DEPTH          = 2**DEFAULT_ADDR_W;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return (bin >> 1) ^ bin;
   endfunction

   // Bit i of the result is the XOR of Gray bits w-1 down to i.
   function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned w);
      logic [31:0] mask;
      logic [31:0] bin;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      bin  = '0;
      for (int i = 0; i < 32; i++) begin
         bin[i] = ^((gray & mask) >> i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, shared by the write- and read-pointer blocks.
module gray2bin_conv #(
   parameter int W = 10
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   // Each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[W-1:i];
   end

endmodule

// File: rtl/write_ptr_ctrl.sv
// Write-domain pointer and flag controller for the async FIFO: binary/Gray write
// pointer, full, programmable almost-full, occupancy count and sticky overflow.
module write_ptr_ctrl
   import async_fifo_pkg::*;
#(
   parameter int          ADDR_W    = DEFAULT_ADDR_W,
   parameter int unsigned AFULL_RST = 2**(ADDR_W-1)
) (
   input  logic              wclk,
   input  logic              wrst,
   input  logic              winc,
   input  logic [ADDR_W:0]   wq2_rptr,
   input  logic [ADDR_W:0]   afull_thresh,
   input  logic              afull_ld,
   input  logic              wovf_clr,
   output logic [ADDR_W-1:0] waddr,
   output logic              wen,
   output logic [ADDR_W:0]   wptr,
   output logic              wfull,
   output logic              walmost_full,
   output logic [ADDR_W:0]   wcount,
   output logic              wovf
);

   localparam int PW = ADDR_W + 1;

   logic [PW-1:0] bin_q;
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] wcount_q;
   logic [PW-1:0] thr_q;
   logic          wfull_q;
   logic          walmost_full_q;
   logic          wovf_q;

   logic [PW-1:0] bin_d;
   logic [PW-1:0] gray_d;
   logic [PW-1:0] rbin;
   logic [PW-1:0] occ_d;
   logic [PW-1:0] full_ptr;
   logic          wfull_d;
   logic          walmost_full_d;

   gray2bin_conv #(.W(PW)) u_rptr_conv (
      .gray_i (wq2_rptr),
      .bin_o  (rbin)
   );

   assign wen   = winc & ~wfull_q & ~wrst;
   assign bin_d = bin_q + PW'(wen);

   logic [31:0] gray_wide;
   assign gray_wide = bin2gray(32'(bin_d));
   assign gray_d    = gray_wide[PW-1:0];

   // Full when the write pointer is exactly one lap ahead of the read pointer:
   // in Gray code that is the top two bits inverted, the rest equal.
   assign full_ptr = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
   assign wfull_d  = (gray_d == full_ptr);

   assign occ_d          = bin_d - rbin;
   assign walmost_full_d = (thr_q != '0) && (occ_d >= thr_q);

   always_ff @(posedge wclk) begin
      if (wrst) begin
         bin_q          <= '0;
         wptr_q         <= '0;
         wfull_q        <= 1'b0;
         walmost_full_q <= 1'b0;
         wcount_q       <= '0;
         wovf_q         <= 1'b0;
         thr_q          <= PW'(AFULL_RST);
      end else begin
         bin_q          <= bin_d;
         wptr_q         <= gray_d;
         wfull_q        <= wfull_d;
         walmost_full_q <= walmost_full_d;
         wcount_q       <= occ_d;
         if (afull_ld) begin
            thr_q <= afull_thresh;
         end
         // A rejected write in the same cycle as a clear keeps the error visible.
         if (winc && wfull_q) begin
            wovf_q <= 1'b1;
         end else if (wovf_clr) begin
            wovf_q <= 1'b0;
         end
      end
   end

   assign waddr        = bin_q[ADDR_W-1:0];
   assign wptr         = wptr_q;
   assign wfull        = wfull_q;
   assign walmost_full = walmost_full_q;
   assign wcount       = wcount_q;
   assign wovf         = wovf_q;

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Scoreboard bench for write_ptr_ctrl (ADDR_W=4): directed scenarios followed by
// randomized traffic, checked against an occupancy-based reference model.
module tb_write_ptr_ctrl;

   localparam int AW = 4;
   localparam int D  = 16;

   logic          wclk = 1'b0;
   logic          wrst = 1'b1;
   logic          winc = 1'b0;
   logic [AW:0]   wq2_rptr = '0;
   logic [AW:0]   afull_thresh = '0;
   logic          afull_ld = 1'b0;
   logic          wovf_clr = 1'b0;
   logic [AW-1:0] waddr;
   logic          wen;
   logic [AW:0]   wptr;
   logic          wfull;
   logic          walmost_full;
   logic [AW:0]   wcount;
   logic          wovf;

   write_ptr_ctrl #(.ADDR_W(AW)) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .winc         (winc),
      .wq2_rptr     (wq2_rptr),
      .afull_thresh (afull_thresh),
      .afull_ld     (afull_ld),
      .wovf_clr     (wovf_clr),
      .waddr        (waddr),
      .wen          (wen),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wcount       (wcount),
      .wovf         (wovf)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      bit          chk_addr;
      logic        wen;
      logic [AW-1:0] waddr;
      logic [AW:0] wptr;
      logic        full;
      logic        af;
      logic [AW:0] cnt;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errs    = 0;

   // Reference model: total writes accepted and total reads seen, as plain integers.
   int m_wr   = 0;
   int m_rd   = 0;
   int m_thr  = 8;
   bit m_full = 0;
   bit m_af   = 0;
   int m_cnt  = 0;
   bit m_ovf  = 0;
   bit m_init = 0;

   function automatic logic [AW:0] gray_of(input int v);
      logic [AW:0] b;
      b = v[AW:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit inc, input int rd,
                       input logic [AW:0] thr_in, input bit ld, input bit clr);
      exp_t e;
      bit   ovf_set;
      int   occ;
      @(negedge wclk);
      wrst         = rst;
      winc         = inc;
      wq2_rptr     = gray_of(rd);
      afull_thresh = thr_in;
      afull_ld     = ld;
      wovf_clr     = clr;
      e.chk_addr = m_init;
      e.waddr    = AW'(m_wr % D);
      e.wen      = !rst && inc && !m_full;
      if (rst) begin
         m_wr = 0; m_rd = 0; m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0; m_thr = 8;
         m_init = 1;
      end else begin
         ovf_set = inc && m_full;
         if (e.wen) m_wr++;
         m_rd   = rd;
         occ    = m_wr - m_rd;
         m_full = (occ == D);
         m_cnt  = occ;
         m_af   = (m_thr != 0) && (occ >= m_thr);
         if (ld) m_thr = int'(thr_in);
         if (ovf_set) m_ovf = 1;
         else if (clr) m_ovf = 0;
      end
      e.wptr = gray_of(m_wr);
      e.full = m_full;
      e.af   = m_af;
      e.cnt  = AW'(0) + (AW+1)'(m_cnt);
      e.ovf  = m_ovf;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge wclk);
         #2;
         if (sb.size() > 0) begin
            e = sb[0];
            chk("wen", 32'(wen), 32'(e.wen));
            if (e.chk_addr) chk("waddr", 32'(waddr), 32'(e.waddr));
            @(posedge wclk);
            #1;
            e = sb.pop_front();
            chk("wptr", 32'(wptr), 32'(e.wptr));
            chk("wfull", 32'(wfull), 32'(e.full));
            chk("walmost_full", 32'(walmost_full), 32'(e.af));
            chk("wcount", 32'(wcount), 32'(e.cnt));
            chk("wovf", 32'(wovf), 32'(e.ovf));
         end
      end
   end

   initial begin : driver
      int rd_inc;
      int room;
      // Reset held with writes requested, then fill to full and overflow.
      step(1, 1, 0, '0, 0, 0);
      step(1, 1, 0, '0, 0, 0);
      for (int i = 0; i < D; i++) step(0, 1, 0, '0, 0, 0);
      step(0, 1, 0, '0, 0, 0);
      step(0, 1, 0, '0, 0, 1);
      step(0, 0, 0, '0, 0, 1);
      step(0, 0, 0, '0, 0, 0);
      // Three reads seen, then refill to full.
      step(0, 0, 3, '0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 3, '0, 0, 0);
      step(0, 0, 3, '0, 0, 0);
      // Almost-full threshold 12, then disabled with 0.
      step(1, 0, 0, '0, 0, 0);
      step(0, 0, 0, 5'd12, 1, 0);
      for (int i = 0; i < 14; i++) step(0, 1, 0, '0, 0, 0);
      step(0, 1, 0, '0, 1, 0);
      step(0, 1, 0, '0, 0, 0);
      step(0, 1, 0, '0, 0, 0);
      // Wrap: read pointer trails the write pointer by 5.
      step(1, 0, 0, '0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, '0, 0, 0);
      for (int i = 0; i < 100; i++) step(0, 1, m_wr + 1 - 5, '0, 0, 0);
      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         room   = m_wr - m_rd;
         rd_inc = $urandom_range(2);
         if (rd_inc > room) rd_inc = room;
         if ($urandom_range(99) == 0) begin
            step(1, $urandom_range(1), 0, '0, 0, 0);
         end else begin
            step(0, ($urandom_range(3) != 0), m_rd + rd_inc,
                 (AW+1)'($urandom_range(31)), ($urandom_range(15) == 0),
                 ($urandom_range(7) == 0));
         end
      end
      step(0, 0, m_rd, '0, 0, 0);
      repeat (4) @(posedge wclk);
      #3;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
